// File: rtl/avmm_panel_ctrl.sv
// rtl/avmm_panel_ctrl.sv - Avalon-MM front panel peripheral: 7-seg digits, LEDs, synchronised switches
module avmm_panel_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int LED_W      = 8,
  parameter int SW_W       = 8,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              address,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    readdatavalid,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [LED_W-1:0]        leds,
  input  logic [SW_W-1:0]         switches,
  output logic                    irq
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int SEG_W = 7 * NUM_DIGITS;
  // RAWSEG storage stops at the 32-bit bus width; wider digit sets see blank segments above it
  localparam int RAW_W = (SEG_W > 32) ? 32 : SEG_W;
  localparam int CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  localparam logic [2:0] A_VALUE  = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_RAWSEG = 3'd2;
  localparam logic [2:0] A_LEDS   = 3'd3;
  localparam logic [2:0] A_SW     = 3'd4;
  localparam logic [2:0] A_EDGE   = 3'd5;
  localparam logic [2:0] A_MASK   = 3'd6;

  // Register file
  logic [VAL_W-1:0]      value_q, value_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  raw_q, raw_d;
  logic                  blink_q, blink_d;
  logic [RAW_W-1:0]      rawseg_q, rawseg_d;
  logic [LED_W-1:0]      led_reg_q, led_reg_d;
  logic [SW_W-1:0]       edge_q, edge_d;
  logic [SW_W-1:0]       mask_q, mask_d;

  // Switch synchroniser and change detector
  logic [SW_W-1:0]       sync1_q, sync2_q, hist_q;
  logic [SW_W-1:0]       sw_change;
  logic [SW_W-1:0]       edge_clr;

  // Bus read side
  logic [31:0]           rd_word;
  logic [31:0]           readdata_q, readdata_d;
  logic                  rdv_q, rdv_d;

  // Blink timebase
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  // Registered panel outputs
  logic [SEG_W-1:0]      hex_q, hex_d;
  logic [LED_W-1:0]      leds_q;
  logic [SEG_W-1:0]      raw_full;

  // Writedata bits outside every implemented field are intentionally ignored
  logic                  unused_wdata;
  assign unused_wdata = ^writedata;

  // Standard active-low glyphs, bit0 = segment a
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // Register writes with field masking; EDGE gets set-over-clear priority
  always_comb begin
    value_d   = value_q;
    en_d      = en_q;
    raw_d     = raw_q;
    blink_d   = blink_q;
    rawseg_d  = rawseg_q;
    led_reg_d = led_reg_q;
    mask_d    = mask_q;
    edge_clr  = '0;
    if (write) begin
      case (address)
        A_VALUE:  value_d   = writedata[VAL_W-1:0];
        A_CTRL: begin
          en_d    = writedata[NUM_DIGITS-1:0];
          raw_d   = writedata[8];
          blink_d = writedata[9];
        end
        A_RAWSEG: rawseg_d  = writedata[RAW_W-1:0];
        A_LEDS:   led_reg_d = writedata[LED_W-1:0];
        A_EDGE:   edge_clr  = writedata[SW_W-1:0];
        A_MASK:   mask_d    = writedata[SW_W-1:0];
        default:  ;
      endcase
    end
    sw_change = sync2_q ^ hist_q;
    edge_d    = (edge_q & ~edge_clr) | sw_change;
  end

  // Read mux; a write in the same cycle suppresses the read entirely
  always_comb begin
    rd_word = '0;
    case (address)
      A_VALUE:  rd_word[VAL_W-1:0] = value_q;
      A_CTRL: begin
        rd_word[NUM_DIGITS-1:0] = en_q;
        rd_word[8]              = raw_q;
        rd_word[9]              = blink_q;
      end
      A_RAWSEG: rd_word[RAW_W-1:0] = rawseg_q;
      A_LEDS:   rd_word[LED_W-1:0] = led_reg_q;
      A_SW:     rd_word[SW_W-1:0]  = sync2_q;
      A_EDGE:   rd_word[SW_W-1:0]  = edge_q;
      A_MASK:   rd_word[SW_W-1:0]  = mask_q;
      default:  ;
    endcase
    rdv_d      = read && !write;
    readdata_d = rdv_d ? rd_word : readdata_q;
  end

  // Free-running blink counter; phase flips each time it wraps
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
    end
  end

  // Per-digit segment selection: decoded nibble or raw pattern, gated by enable and blink
  always_comb begin
    raw_full             = '1;
    raw_full[RAW_W-1:0]  = rawseg_q;
    hex_d                = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en_q[i] && (!blink_q || phase_q)) begin
        hex_d[7*i +: 7] = raw_q ? raw_full[7*i +: 7] : hex_glyph(value_q[4*i +: 4]);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q    <= '0;
      en_q       <= '0;
      raw_q      <= 1'b0;
      blink_q    <= 1'b0;
      rawseg_q   <= '1;
      led_reg_q  <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      cnt_q      <= '0;
      phase_q    <= 1'b1;
      hex_q      <= '1;
      leds_q     <= '0;
    end else begin
      value_q    <= value_d;
      en_q       <= en_d;
      raw_q      <= raw_d;
      blink_q    <= blink_d;
      rawseg_q   <= rawseg_d;
      led_reg_q  <= led_reg_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      sync1_q    <= switches;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      hex_q      <= hex_d;
      leds_q     <= led_reg_q;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign hex           = hex_q;
  assign leds          = leds_q;
  assign irq           = |(edge_q & mask_q);

endmodule
